// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: fetch-state encoding, NOP word and
// default datapath widths.
package mips_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REQ_DROP,
    ST_WAIT,
    ST_FULL,
    ST_DROP
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads a fetched instruction, or clears to a NOP
// bubble. The PC+4 field is only replaced by a real load.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [ADDR_W-1:0]  next_pc4,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4,
  output logic               valid
);

  // Clear wins over load so a redirect always squashes the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= INSTR_W'(NOP_INSTR);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      instr <= INSTR_W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// IF-stage controller: PC, imem request/response handshake, one-entry fetch
// buffer, and application of the hazard unit's stall/flush commands.
module fetch_stage_ctrl
  import mips_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter int               INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write,
  input  logic               ifid_write,
  input  logic               if_flush,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic               ifid_valid,
  output logic               fetch_bubble
);

  fetch_state_t        state, state_next;
  logic [ADDR_W-1:0]   pc, pc_next, pc_plus4, req_addr, target;
  logic [INSTR_W-1:0]  buf_instr;
  logic                advance, redirect, avail, consume;
  logic                enter_req, buf_load;

  assign advance  = pc_write & ifid_write;
  assign redirect = if_flush & pc_write;
  assign target   = jump ? jump_target : branch_target;
  assign pc_plus4 = pc + ADDR_W'(4);

  // An instruction is available either straight off imem in WAIT or from the buffer.
  assign avail        = ((state == ST_WAIT) & imem_rvalid) | (state == ST_FULL);
  assign consume      = advance & ~redirect & avail;
  assign fetch_bubble = advance & ~redirect & ~avail;
  assign pc_next      = redirect ? target : (consume ? pc_plus4 : pc);

  assign imem_req  = (state == ST_REQ) | (state == ST_REQ_DROP);
  assign imem_addr = req_addr;

  always_comb begin
    state_next = state;
    enter_req  = 1'b0;
    buf_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
        enter_req  = 1'b1;
      end
      ST_REQ: begin
        if (imem_gnt)      state_next = redirect ? ST_DROP : ST_WAIT;
        else if (redirect) state_next = ST_REQ_DROP;
      end
      ST_REQ_DROP: begin
        if (imem_gnt) state_next = ST_DROP;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (redirect | consume) begin
            state_next = ST_REQ;
            enter_req  = 1'b1;
          end else begin
            state_next = ST_FULL;
            buf_load   = 1'b1;
          end
        end else if (redirect) begin
          state_next = ST_DROP;
        end
      end
      ST_FULL: begin
        if (redirect | consume) begin
          state_next = ST_REQ;
          enter_req  = 1'b1;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_next = ST_REQ;
          enter_req  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The request address is captured only on entry to REQ, so it stays stable until granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      buf_instr <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (enter_req) req_addr  <= pc_next;
      if (buf_load)  buf_instr <= imem_rdata;
    end
  end

  ifid_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (consume),
    .clear      (redirect | fetch_bubble),
    .next_instr ((state == ST_FULL) ? buf_instr : imem_rdata),
    .next_pc4   (pc_plus4),
    .instr      (ifid_instr),
    .pc4        (ifid_pc4),
    .valid      (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: a flag-based reference model predicts
// each cycle's outputs; a separate monitor pops and compares them.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pc_write = 1'b0, ifid_write = 1'b0, if_flush = 1'b0, jump = 1'b0;
  logic [31:0] jump_target = '0, branch_target = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid, fetch_bubble;

  always #5 clk = ~clk;

  fetch_stage_ctrl #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .ifid_write(ifid_write),
    .if_flush(if_flush), .jump(jump), .jump_target(jump_target),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .fetch_bubble(fetch_bubble)
  );

  typedef struct {
    logic        bubble;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: flags describing what the fetch unit is doing, not states.
  logic [31:0] m_pc, m_req_addr, m_buf, m_instr, m_pc4;
  logic        m_started, m_asking, m_ask_stale, m_pending, m_pend_stale, m_have_buf, m_valid;

  task automatic modelReset();
    m_pc = 0; m_req_addr = 0; m_buf = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_started = 0; m_asking = 0; m_ask_stale = 0; m_pending = 0; m_pend_stale = 0;
    m_have_buf = 0;
  endtask

  task automatic startAsk(input logic [31:0] a);
    m_asking = 1; m_ask_stale = 0; m_req_addr = a;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic pw, input logic iw, input logic fl, input logic jmp,
                               input logic [31:0] jt, input logic [31:0] bt,
                               input logic gnt, input logic rv);
    logic        adv, redir, got, bub;
    logic [31:0] tgt, npc, rd;
    @(negedge clk);
    rd = $urandom;
    pc_write = pw; ifid_write = iw; if_flush = fl; jump = jmp;
    jump_target = jt; branch_target = bt; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
    #1;
    adv   = pw & iw;
    redir = fl & pw;
    tgt   = jmp ? jt : bt;
    got   = (m_pending && !m_pend_stale && rv) || m_have_buf;
    bub   = adv && !redir && !got;
    npc   = m_pc;
    if (redir) begin
      npc = tgt; m_valid = 0; m_instr = 0;
    end else if (adv && got) begin
      m_instr = m_have_buf ? m_buf : rd;
      m_pc4 = m_pc + 32'd4; m_valid = 1; npc = m_pc + 32'd4;
    end else if (adv) begin
      m_valid = 0; m_instr = 0;
    end
    if (!m_started) begin
      m_started = 1; startAsk(npc);
    end else if (m_asking) begin
      if (gnt) begin
        m_asking = 0; m_pending = 1; m_pend_stale = m_ask_stale || redir;
      end else if (redir) m_ask_stale = 1;
    end else if (m_pending) begin
      if (rv) begin
        m_pending = 0;
        if (m_pend_stale || redir || adv) startAsk(npc);
        else begin m_have_buf = 1; m_buf = rd; end
      end else if (redir) m_pend_stale = 1;
    end else if (m_have_buf) begin
      if (redir || adv) begin m_have_buf = 0; startAsk(npc); end
    end
    m_pc = npc;
    sb.push_back('{bub, m_asking, m_req_addr, m_instr, m_pc4, m_valid});
  endtask

  task automatic step(input logic pw, input logic iw);
    applyStimulus(pw, iw, 0, 0, 0, 0, 1, m_pending);
  endtask

  task automatic goWait();
    for (int i = 0; i < 10; i++) if (!m_pending) applyStimulus(1, 1, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic goAsk();
    for (int i = 0; i < 10; i++) if (!m_asking) applyStimulus(1, 1, 0, 0, 0, 0, 1, m_pending);
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) if (sb.size() != 0) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain queued=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_ifid_instr", ifid_instr, 32'h0);
    checkOutput("rst_ifid_pc4", ifid_pc4, 32'h0);
    checkOutput("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    checkOutput("rst_fetch_bubble", {31'd0, fetch_bubble}, 32'd0);
  endtask

  // Monitor: bubble is combinational and checked mid-cycle; registered outputs after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) checkOutput("fetch_bubble", {31'd0, fetch_bubble}, {31'd0, sb[0].bubble});
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("imem_req", {31'd0, imem_req}, {31'd0, e.req});
        checkOutput("imem_addr", imem_addr, e.addr);
        checkOutput("ifid_instr", ifid_instr, e.instr);
        checkOutput("ifid_pc4", ifid_pc4, e.pc4);
        checkOutput("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
      end
    end
  end

  initial begin
    logic        pw, iw, fl, gnt, rv;
    logic [31:0] jt, bt;
    modelReset();
    #1 rst_n = 1'b0;
    #2 checkReset();
    @(posedge clk); #3 rst_n = 1'b1;

    $display("[TB] back-to-back fetch");
    repeat (8) step(1, 1);

    $display("[TB] stall while response arrives");
    goWait();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (2) step(0, 0);
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 0, 1, 0);
    repeat (4) step(1, 1);

    $display("[TB] flush in WAIT");
    goWait();
    applyStimulus(1, 1, 1, 0, 0, 32'h40, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1);
    repeat (4) step(1, 1);

    $display("[TB] flush during stall");
    goWait();
    applyStimulus(0, 1, 1, 0, 0, 32'h80, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 32'h80, 1, 0);
    repeat (5) step(1, 1);

    $display("[TB] jump while request pending");
    goAsk();
    applyStimulus(1, 1, 1, 1, 32'h100, 32'h0, 0, 0);
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1);
    repeat (4) step(1, 1);

    $display("[TB] pc+4 wrap");
    goAsk();
    applyStimulus(1, 1, 1, 1, 32'hFFFF_FFFC, 32'h0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1);
    repeat (4) step(1, 1);

    $display("[TB] slow imem and reset mid-WAIT");
    goWait();
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    goWait();
    drain();
    pc_write = 1'b0; ifid_write = 1'b0; if_flush = 1'b0;
    rst_n = 1'b0;
    #1 checkReset();
    modelReset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    $display("[TB] random traffic");
    for (int n = 0; n < 2500; n++) begin
      pw  = ($urandom_range(0, 99) < 85);
      iw  = ($urandom_range(0, 99) < 85);
      fl  = ($urandom_range(0, 99) < 10);
      jt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      bt  = $urandom & 32'hFFFF_FFFC;
      gnt = ($urandom_range(0, 99) < 60);
      rv  = m_pending ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      applyStimulus(pw, iw, fl, $urandom_range(0, 1) == 1, jt, bt, gnt, rv);
    end
    drain();

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
